// File: rtl/mem_stage_hs.sv
// -----------------------------------------------------------------------------
// mem_stage_hs -- memory pipeline stage with a request/acknowledge data bus.
//
// Accepts one instruction at a time from EX. Non-memory instructions retire
// the cycle after acceptance carrying the ALU result. Loads and stores are
// registered, presented on the bus (held stable until bus_ack) and retire the
// cycle after the ack, or with fault_out after TIMEOUT unacknowledged cycles.
//
// Parameters
//   IO_SEL_BIT  address bit that selects IO (1) over RAM (0)
//   TIMEOUT     bus cycles to wait for bus_ack before aborting (1..65535)
//
// Optional feature macro
//   MISALIGN_TRAP_EN  when defined, misaligned half/word accesses retire with
//                     fault_out and never reach the bus; when undefined they
//                     are forced onto the naturally aligned lane.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   in_valid/in_ready            EX -> MEM handshake
//   iw_in, alu_in, rs2_data_in   instruction word, address/result, store data
//   wb_reg_in, wb_enable_in      destination register and its write enable
//   bus_*                        request/ack data bus (word address, lanes)
//   out_valid ... fault_out      one-cycle retire pulse and write-back fields
//   df_mem_*                     forwarding view of the retiring instruction
// -----------------------------------------------------------------------------
module mem_stage_hs #(
    parameter int IO_SEL_BIT = 31,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_enable_in,
    output logic        bus_req,
    output logic        bus_sel_io,
    output logic [29:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        out_valid,
    output logic [31:0] iw_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_enable_out,
    output logic        fault_out,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    localparam logic [6:0]  OP_LOAD      = 7'b0000011;
    localparam logic [6:0]  OP_STORE     = 7'b0100011;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    state_t      state_r;
    logic [15:0] timer_r;
    logic [31:0] iw_r;
    logic [1:0]  off_r;
    logic [4:0]  wb_reg_r;
    logic        wb_en_r;

    logic        accept_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        is_mem_s;
    logic [1:0]  size_s;
    logic [1:0]  off_s;
    logic [1:0]  eff_off_s;
    logic        trap_s;

    // Byte enables for an access of the given size at the (aligned) offset.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        wd = data;
        case (size)
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Load lane extraction and sign/zero extension from funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [2:0] funct3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign accept_s   = in_valid & in_ready;
    assign is_load_s  = (iw_in[6:0] == OP_LOAD);
    assign is_store_s = (iw_in[6:0] == OP_STORE);
    assign is_mem_s   = is_load_s | is_store_s;
    assign size_s     = iw_in[13:12];
    assign off_s      = alu_in[1:0];

    // Effective lane offset: halves snap to an even lane, words to lane 0.
    always_comb begin
        eff_off_s = off_s;
        case (size_s)
            2'b00:   eff_off_s = off_s;
            2'b01:   eff_off_s = {off_s[1], 1'b0};
            default: eff_off_s = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Misaligned halves and words are refused before they reach the bus.
    always_comb begin
        trap_s = 1'b0;
        case (size_s)
            2'b00:   trap_s = 1'b0;
            2'b01:   trap_s = is_mem_s & off_s[0];
            default: trap_s = is_mem_s & (off_s != 2'b00);
        endcase
    end
`else
    assign trap_s = 1'b0;
`endif

    // Stage FSM with registered bus and write-back outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            timer_r       <= 16'h0000;
            iw_r          <= 32'h00000000;
            off_r         <= 2'b00;
            wb_reg_r      <= 5'd0;
            wb_en_r       <= 1'b0;
            in_ready      <= 1'b1;
            bus_req       <= 1'b0;
            bus_sel_io    <= 1'b0;
            bus_addr      <= 30'h00000000;
            bus_we        <= 1'b0;
            bus_be        <= 4'b0000;
            bus_wdata     <= 32'h00000000;
            out_valid     <= 1'b0;
            iw_out        <= 32'h00000000;
            wb_data_out   <= 32'h00000000;
            wb_reg_out    <= 5'd0;
            wb_enable_out <= 1'b0;
            fault_out     <= 1'b0;
        end else begin
            out_valid     <= 1'b0;
            wb_enable_out <= 1'b0;
            fault_out     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (!is_mem_s || trap_s) begin
                            // Retire directly: ALU result, or a misalign fault.
                            out_valid     <= 1'b1;
                            iw_out        <= iw_in;
                            wb_data_out   <= alu_in;
                            wb_reg_out    <= wb_reg_in;
                            wb_enable_out <= wb_enable_in & ~is_mem_s;
                            fault_out     <= trap_s;
                        end else begin
                            state_r    <= ST_BUS;
                            timer_r    <= 16'h0000;
                            in_ready   <= 1'b0;
                            bus_req    <= 1'b1;
                            bus_sel_io <= alu_in[IO_SEL_BIT];
                            bus_addr   <= alu_in[31:2];
                            bus_we     <= is_store_s;
                            bus_be     <= lane_enables(size_s, eff_off_s);
                            bus_wdata  <= lane_wdata(size_s, rs2_data_in);
                            iw_r       <= iw_in;
                            off_r      <= eff_off_s;
                            wb_reg_r   <= wb_reg_in;
                            wb_en_r    <= wb_enable_in & is_load_s;
                        end
                    end
                end
                ST_BUS: begin
                    // The ack is checked first so it wins over an expiring timer.
                    if (bus_ack) begin
                        state_r       <= ST_IDLE;
                        in_ready      <= 1'b1;
                        bus_req       <= 1'b0;
                        bus_we        <= 1'b0;
                        bus_be        <= 4'b0000;
                        out_valid     <= 1'b1;
                        iw_out        <= iw_r;
                        wb_data_out   <= load_extract(bus_rdata, iw_r[14:12], off_r);
                        wb_reg_out    <= wb_reg_r;
                        wb_enable_out <= wb_en_r;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_r     <= ST_IDLE;
                        in_ready    <= 1'b1;
                        bus_req     <= 1'b0;
                        bus_we      <= 1'b0;
                        bus_be      <= 4'b0000;
                        out_valid   <= 1'b1;
                        iw_out      <= iw_r;
                        wb_data_out <= 32'h00000000;
                        wb_reg_out  <= wb_reg_r;
                        fault_out   <= 1'b1;
                    end else begin
                        timer_r <= timer_r + 16'h0001;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b1;
                    bus_req  <= 1'b0;
                end
            endcase
        end
    end

    assign df_mem_enable = out_valid & wb_enable_out;
    assign df_mem_reg    = wb_reg_out;
    assign df_mem_data   = wb_data_out;

endmodule
